elevator_dispatcher: RTL and testbench

//  Group dispatcher sharing hall calls (up/down request bitmaps) between two elevator cars.

---
 rtl/elevator_pkg.sv | 35 +++
 rtl/elevator_dispatcher_cost.sv | 50 +++++
 rtl/elevator_dispatcher.sv | 197 +++++++++++++++++++
 tb/tb_elevator_dispatcher.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
//   Shared definitions for the two-car group dispatcher:
//     - default floor count and wrong-way penalty
//     - car motion encoding (DIR_IDLE / DIR_UP / DIR_DOWN; 2'b11 reads as idle)
//     - dispatcher FSM state enum
//     - slot decode helpers. Slots 0..FLOORS-1 are up-calls and slots
//       FLOORS..2*FLOORS-1 are down-calls.
// ---------------------------------------------------------------------------
package elevator_pkg;

   localparam int FLOORS_DEF  = 8;
   localparam int PENALTY_DEF = 16;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL  = 2'd1,
      ST_OFFER = 2'd2
   } state_t;

   // Floor index addressed by a slot.
   function automatic int slot_floor(input int slot, input int floors);
      return (slot < floors) ? slot : slot - floors;
   endfunction

   // 1 when the slot holds an up-call.
   function automatic logic slot_is_up(input int slot, input int floors);
      return (slot < floors);
   endfunction

endpackage

// File: rtl/elevator_dispatcher_cost.sv
// ---------------------------------------------------------------------------
// dispatch_cost
//   Combinational cost of sending one car to one hall call.
//   Ports:
//     i_en       car in service (a disabled car reports all-ones cost)
//     i_pos      car current floor
//     i_dir      car motion (DIR_IDLE / DIR_UP / DIR_DOWN, 2'b11 = idle)
//     i_floor    call floor
//     i_call_up  call direction, 1 = up
//     o_cost     distance, plus PENALTY when the car moves away from the
//                call or against its direction
// ---------------------------------------------------------------------------
module dispatch_cost
   import elevator_pkg::*;
#(
   parameter  int FLOORS  = FLOORS_DEF,
   parameter  int PENALTY = PENALTY_DEF,
   localparam int FW      = $clog2(FLOORS),
   localparam int CW      = $clog2(FLOORS + PENALTY) + 1
) (
   input  logic          i_en,
   input  logic [FW-1:0] i_pos,
   input  logic [1:0]    i_dir,
   input  logic [FW-1:0] i_floor,
   input  logic          i_call_up,
   output logic [CW-1:0] o_cost
);

   logic [FW-1:0] w_dist;
   logic          w_on_the_way;

   always_comb begin
      w_dist       = (i_pos > i_floor) ? (i_pos - i_floor) : (i_floor - i_pos);
      w_on_the_way = 1'b1;
      case (i_dir)
         DIR_UP:   w_on_the_way = (i_floor >= i_pos) &&  i_call_up;
         DIR_DOWN: w_on_the_way = (i_floor <= i_pos) && !i_call_up;
         default:  w_on_the_way = 1'b1;   // idle, and 2'b11 treated as idle
      endcase
   end

   always_comb begin
      o_cost = '1;
      if (i_en) begin
         if (w_on_the_way) o_cost = CW'(w_dist);
         else              o_cost = CW'(w_dist) + CW'(PENALTY);
      end
   end

endmodule

// File: rtl/elevator_dispatcher.sv
// ---------------------------------------------------------------------------
// elevator_dispatcher
//   Shares hall calls between two cars. Pending, unassigned calls are scanned
//   round-robin from a pointer; the chosen call is costed for both cars and
//   offered to the cheaper enabled car. Accepted calls are held in a mask
//   until their hall button clears, so no call is dispatched twice.
//
//   Ports:
//     clk, reset         clock, synchronous active-high reset
//     i_hall_up/down     pending hall calls (level, held until serviced)
//     i_car_en           per-car in-service flags
//     i_car0/1_pos       car floor indices
//     i_car0/1_dir       car motion (00 idle, 01 up, 10 down, 11 idle)
//     o_asg_valid        assignment offered
//     o_asg_car          target car
//     o_asg_floor        call floor
//     o_asg_dir          call direction (1 up, 0 down)
//     i_asg_ready        target car accepts
//     o_asg_mask         assigned calls: [F-1:0] up, [2F-1:F] down
//     o_state            FSM state, for observation
//
//   Handshake: o_asg_valid/car/floor/dir are held stable while in OFFER until
//   a cycle with i_asg_ready=1 transfers the assignment. The offer is
//   withdrawn instead (no transfer, ready ignored) in any cycle where the
//   offered hall bit or the target car's enable is low.
// ---------------------------------------------------------------------------
module elevator_dispatcher
   import elevator_pkg::*;
#(
   parameter  int FLOORS  = FLOORS_DEF,
   parameter  int PENALTY = PENALTY_DEF,
   localparam int FW      = $clog2(FLOORS),
   localparam int SLOTS   = 2 * FLOORS,
   localparam int SW      = $clog2(SLOTS),
   localparam int CW      = $clog2(FLOORS + PENALTY) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [FLOORS-1:0] i_hall_up,
   input  logic [FLOORS-1:0] i_hall_down,
   input  logic [1:0]       i_car_en,
   input  logic [FW-1:0]    i_car0_pos,
   input  logic [FW-1:0]    i_car1_pos,
   input  logic [1:0]       i_car0_dir,
   input  logic [1:0]       i_car1_dir,
   output logic             o_asg_valid,
   output logic             o_asg_car,
   output logic [FW-1:0]    o_asg_floor,
   output logic             o_asg_dir,
   input  logic             i_asg_ready,
   output logic [SLOTS-1:0] o_asg_mask,
   output logic [1:0]       o_state
);

   // Up at the top floor and down at the bottom floor cannot exist.
   localparam logic [SLOTS-1:0] INVALID_SLOTS = SLOTS'(3) << (FLOORS - 1);
   localparam logic [SLOTS-1:0] VALID_SLOTS   = ~INVALID_SLOTS;

   state_t           r_state;
   state_t           w_state_next;
   logic [SW-1:0]    r_ptr;
   logic [SW-1:0]    r_slot;
   logic             r_fair;
   logic [SLOTS-1:0] r_mask;
   logic             r_asg_car;
   logic [FW-1:0]    r_asg_floor;
   logic             r_asg_dir;

   logic [SLOTS-1:0] w_pending;
   logic [SLOTS-1:0] w_eligible;
   logic             w_found;
   logic [SW-1:0]    w_pick;
   logic [SW-1:0]    w_scan_idx;
   logic             w_any_en;
   logic [FW-1:0]    w_call_floor;
   logic             w_call_up;
   logic [CW-1:0]    w_cost0;
   logic [CW-1:0]    w_cost1;
   logic             w_pick_car;
   logic             w_cancel;
   logic             w_accept;
   logic [SW-1:0]    w_ptr_next;

   assign w_pending  = {i_hall_down, i_hall_up};
   assign w_eligible = w_pending & ~r_mask & VALID_SLOTS;
   assign w_any_en   = |i_car_en;

   // First eligible slot at or after the pointer, wrapping.
   always_comb begin
      w_found    = 1'b0;
      w_pick     = '0;
      w_scan_idx = '0;
      for (int k = 0; k < SLOTS; k++) begin
         w_scan_idx = SW'((int'(r_ptr) + k) % SLOTS);
         if (!w_found && w_eligible[w_scan_idx]) begin
            w_found = 1'b1;
            w_pick  = w_scan_idx;
         end
      end
   end

   assign w_call_floor = FW'(slot_floor(int'(r_slot), FLOORS));
   assign w_call_up    = slot_is_up(int'(r_slot), FLOORS);

   dispatch_cost #(.FLOORS(FLOORS), .PENALTY(PENALTY)) u_cost0 (
      .i_en      (i_car_en[0]),
      .i_pos     (i_car0_pos),
      .i_dir     (i_car0_dir),
      .i_floor   (w_call_floor),
      .i_call_up (w_call_up),
      .o_cost    (w_cost0)
   );

   dispatch_cost #(.FLOORS(FLOORS), .PENALTY(PENALTY)) u_cost1 (
      .i_en      (i_car_en[1]),
      .i_pos     (i_car1_pos),
      .i_dir     (i_car1_dir),
      .i_floor   (w_call_floor),
      .i_call_up (w_call_up),
      .o_cost    (w_cost1)
   );

   // Ties go to the car named by the fairness bit. An enabled car always
   // costs less than all-ones, so a tie never selects a disabled car unless
   // both are disabled, which EVAL filters out.
   always_comb begin
      if (w_cost1 < w_cost0)      w_pick_car = 1'b1;
      else if (w_cost0 < w_cost1) w_pick_car = 1'b0;
      else                        w_pick_car = r_fair;
   end

   // Cancel takes priority over ready in the same cycle.
   assign w_cancel = (r_state == ST_OFFER) &&
                     (!w_pending[r_slot] || !i_car_en[r_asg_car]);
   assign w_accept = (r_state == ST_OFFER) && i_asg_ready && !w_cancel;

   assign w_ptr_next = (r_slot == SW'(SLOTS - 1)) ? '0 : r_slot + SW'(1);

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // FSM: next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_found && w_any_en) w_state_next = ST_EVAL;
         ST_EVAL:  w_state_next = w_any_en ? ST_OFFER : ST_IDLE;
         ST_OFFER: if (w_cancel || w_accept) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      o_asg_valid = (r_state == ST_OFFER);
      o_state     = r_state;
   end

   assign o_asg_car   = r_asg_car;
   assign o_asg_floor = r_asg_floor;
   assign o_asg_dir   = r_asg_dir;
   assign o_asg_mask  = r_mask;

   // Datapath: scan pointer, selected slot, assignment, fairness, mask.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr       <= '0;
         r_slot      <= '0;
         r_fair      <= 1'b0;
         r_mask      <= '0;
         r_asg_car   <= 1'b0;
         r_asg_floor <= '0;
         r_asg_dir   <= 1'b0;
      end else begin
         // A call that drops frees its mask bit; an accepted call claims one.
         r_mask <= (r_mask & w_pending) | (w_accept ? (SLOTS'(1) << r_slot) : '0);

         if (r_state == ST_IDLE && w_found && w_any_en)
            r_slot <= w_pick;

         if (r_state == ST_EVAL) begin
            r_asg_car   <= w_pick_car;
            r_asg_floor <= w_call_floor;
            r_asg_dir   <= w_call_up;
         end

         if (w_accept) begin
            r_ptr  <= w_ptr_next;
            r_fair <= ~r_asg_car;
         end
      end
   end

endmodule

// File: tb/tb_elevator_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_elevator_dispatcher
//   Table of single-call dispatch vectors plus hand-written sequences for
//   fairness, spacing, stalls, cancels, round-robin order, reset mid-offer
//   and the all-cars-disabled case. Expected {car, floor, dir} triples are
//   queued when a call is raised and popped when the DUT offers.
// ---------------------------------------------------------------------------
module tb_elevator_dispatcher;
   import elevator_pkg::*;

   localparam int FLOORS = 8;
   localparam int FW     = 3;
   localparam int SLOTS  = 16;
   localparam int SBW    = FW + 2;

   typedef struct {
      logic [7:0] up;
      logic [7:0] down;
      logic [1:0] en;
      logic [2:0] p0;
      logic [2:0] p1;
      logic [1:0] d0;
      logic [1:0] d1;
      logic       car;
      logic [2:0] floor;
      logic       dir;
   } vec_t;

   logic             clk;
   logic             reset;
   logic [7:0]       hall_up, hall_down;
   logic [1:0]       car_en;
   logic [FW-1:0]    car0_pos, car1_pos;
   logic [1:0]       car0_dir, car1_dir;
   logic             asg_valid, asg_car, asg_dir, asg_ready;
   logic [FW-1:0]    asg_floor;
   logic [SLOTS-1:0] asg_mask;
   logic [1:0]       state;

   int               n_checks = 0;
   int               n_err    = 0;
   logic [SBW-1:0]   exp_q[$];
   vec_t             vecs[7];

   elevator_dispatcher #(.FLOORS(8), .PENALTY(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_hall_up   (hall_up),
      .i_hall_down (hall_down),
      .i_car_en    (car_en),
      .i_car0_pos  (car0_pos),
      .i_car1_pos  (car1_pos),
      .i_car0_dir  (car0_dir),
      .i_car1_dir  (car1_dir),
      .o_asg_valid (asg_valid),
      .o_asg_car   (asg_car),
      .o_asg_floor (asg_floor),
      .o_asg_dir   (asg_dir),
      .i_asg_ready (asg_ready),
      .o_asg_mask  (asg_mask),
      .o_state     (state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      hall_up   = '0;
      hall_down = '0;
      car_en    = 2'b11;
      car0_pos  = '0;
      car1_pos  = '0;
      car0_dir  = DIR_IDLE;
      car1_dir  = DIR_IDLE;
      asg_ready = 1'b0;
      reset     = 1'b1;
      repeat (2) @(negedge clk);
      reset     = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_cars(input logic [1:0] en, input logic [2:0] p0, input logic [1:0] d0,
                           input logic [2:0] p1, input logic [1:0] d1);
      car_en   = en;
      car0_pos = p0;
      car0_dir = d0;
      car1_pos = p1;
      car1_dir = d1;
   endtask

   task automatic set_hall(input logic [7:0] up, input logic [7:0] down);
      hall_up   = up;
      hall_down = down;
   endtask

   // Wait (bounded) for an offer; check latency when exp_lat > 0 and
   // compare the offered triple against the scoreboard head.
   task automatic expect_offer(input string name, input int exp_lat);
      int             cyc;
      bit             seen;
      logic [SBW-1:0] exp;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (asg_valid) seen = 1'b1;
      end
      check({name, " offer"}, 32'(seen), 32'd1);
      if (exp_q.size() == 0) begin
         check({name, " scoreboard"}, 32'd0, 32'd1);
      end else begin
         exp = exp_q.pop_front();
         if (seen) begin
            if (exp_lat > 0) check({name, " latency"}, 32'(cyc), 32'(exp_lat));
            check({name, " car/floor/dir"}, {27'd0, asg_car, asg_floor, asg_dir}, 32'(exp));
         end
      end
   endtask

   task automatic accept(input string name, input logic [15:0] exp_mask);
      asg_ready = 1'b1;
      @(negedge clk);
      asg_ready = 1'b0;
      check({name, " valid after accept"}, 32'(asg_valid), 32'd0);
      check({name, " mask after accept"}, 32'(asg_mask), 32'(exp_mask));
   endtask

   // ---------------- stimulus / scoreboard ----------------
   initial begin
      logic [15:0] m;
      int          slot;
      int          n_off;
      int          t_off[2];
      bit          any_valid;
      logic [SBW-1:0] e;

      //           up     down   en     p0    p1    d0        d1        car   flr   dir
      vecs[0] = '{8'h04, 8'h00, 2'b11, 3'd0, 3'd7, DIR_IDLE, DIR_IDLE, 1'b0, 3'd2, 1'b1};
      vecs[1] = '{8'h10, 8'h00, 2'b11, 3'd3, 3'd6, DIR_DOWN, DIR_IDLE, 1'b1, 3'd4, 1'b1};
      vecs[2] = '{8'h00, 8'h20, 2'b10, 3'd5, 3'd0, DIR_IDLE, DIR_IDLE, 1'b1, 3'd5, 1'b0};
      vecs[3] = '{8'h40, 8'h00, 2'b11, 3'd6, 3'd5, DIR_DOWN, DIR_UP,   1'b1, 3'd6, 1'b1};
      vecs[4] = '{8'h00, 8'h20, 2'b11, 3'd6, 3'd2, DIR_DOWN, DIR_IDLE, 1'b0, 3'd5, 1'b0};
      vecs[5] = '{8'h00, 8'h04, 2'b11, 3'd4, 3'd4, 2'b11,    DIR_UP,   1'b0, 3'd2, 1'b0};
      vecs[6] = '{8'h08, 8'h00, 2'b11, 3'd5, 3'd0, DIR_UP,   DIR_IDLE, 1'b1, 3'd3, 1'b1};

      // Reset state
      do_reset();
      check("reset valid", 32'(asg_valid), 32'd0);
      check("reset mask",  32'(asg_mask),  32'd0);
      check("reset state", 32'(state),     32'(ST_IDLE));
      check("reset car/floor/dir", {27'd0, asg_car, asg_floor, asg_dir}, 32'd0);

      // Table-driven single-call dispatch
      for (int i = 0; i < 7; i++) begin
         do_reset();
         set_cars(vecs[i].en, vecs[i].p0, vecs[i].d0, vecs[i].p1, vecs[i].d1);
         set_hall(vecs[i].up, vecs[i].down);
         exp_q.push_back({vecs[i].car, vecs[i].floor, vecs[i].dir});
         expect_offer($sformatf("vec%0d", i), 2);
         slot = vecs[i].dir ? int'(vecs[i].floor) : FLOORS + int'(vecs[i].floor);
         m = 16'd1 << slot;
         accept($sformatf("vec%0d", i), m);
         set_hall(8'h00, 8'h00);
         @(negedge clk);
         check($sformatf("vec%0d mask freed", i), 32'(asg_mask), 32'd0);
      end

      // Fairness on ties and 3-cycle spacing with ready held high
      do_reset();
      set_cars(2'b11, 3'd3, DIR_IDLE, 3'd3, DIR_IDLE);
      exp_q.push_back({1'b0, 3'd5, 1'b1});
      exp_q.push_back({1'b1, 3'd1, 1'b0});
      set_hall(8'h20, 8'h02);
      asg_ready = 1'b1;
      n_off = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (asg_valid) begin
            if (n_off < 2) t_off[n_off] = c;
            n_off++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("fair car/floor/dir", {27'd0, asg_car, asg_floor, asg_dir}, 32'(e));
            end else begin
               check("fair scoreboard", 32'd0, 32'd1);
            end
         end
      end
      asg_ready = 1'b0;
      check("fair offer count", 32'(n_off), 32'd2);
      if (n_off >= 2) begin
         check("fair first latency", 32'(t_off[0]), 32'd2);
         check("fair spacing", 32'(t_off[1] - t_off[0]), 32'd3);
      end
      check("fair mask", 32'(asg_mask), 32'h0220);
      exp_q.delete();

      // Stall: outputs stable while ready low, then hall drop cancels
      do_reset();
      set_cars(2'b11, 3'd0, DIR_IDLE, 3'd7, DIR_IDLE);
      set_hall(8'h04, 8'h00);
      exp_q.push_back({1'b0, 3'd2, 1'b1});
      expect_offer("stall", 2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall hold", {26'd0, asg_valid, asg_car, asg_floor, asg_dir},
               {26'd0, 1'b1, 1'b0, 3'd2, 1'b1});
      end
      set_hall(8'h00, 8'h00);
      @(negedge clk);
      check("cancel valid", 32'(asg_valid), 32'd0);
      check("cancel mask",  32'(asg_mask),  32'd0);
      any_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (asg_valid) any_valid = 1'b1;
      end
      check("cancel no reoffer", 32'(any_valid), 32'd0);

      // Car disable with simultaneous ready: cancel wins, call re-dispatched
      do_reset();
      set_cars(2'b11, 3'd1, DIR_IDLE, 3'd6, DIR_IDLE);
      set_hall(8'h00, 8'h04);
      exp_q.push_back({1'b0, 3'd2, 1'b0});
      expect_offer("en drop", 2);
      asg_ready = 1'b1;
      car_en    = 2'b10;
      @(negedge clk);
      asg_ready = 1'b0;
      check("en drop valid", 32'(asg_valid), 32'd0);
      check("en drop mask",  32'(asg_mask),  32'd0);
      exp_q.push_back({1'b1, 3'd2, 1'b0});
      expect_offer("en redispatch", 2);
      accept("en redispatch", 16'h0400);

      // Round-robin order; invalid slots never offered
      do_reset();
      set_cars(2'b11, 3'd0, DIR_IDLE, 3'd0, DIR_IDLE);
      set_hall(8'hA2, 8'h01);
      exp_q.push_back({1'b0, 3'd1, 1'b1});
      expect_offer("rr slot1", 2);
      accept("rr slot1", 16'h0002);
      set_hall(8'hA0, 8'h01);
      @(negedge clk);
      check("rr drop frees bit", 32'(asg_mask), 32'd0);
      set_hall(8'hA2, 8'h01);
      exp_q.push_back({1'b1, 3'd5, 1'b1});
      expect_offer("rr slot5", 0);
      accept("rr slot5", 16'h0020);
      exp_q.push_back({1'b0, 3'd1, 1'b1});
      expect_offer("rr slot1 again", 2);
      accept("rr slot1 again", 16'h0022);
      any_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (asg_valid) any_valid = 1'b1;
      end
      check("rr invalid slots idle", 32'(any_valid), 32'd0);

      // Reset mid-OFFER
      do_reset();
      set_cars(2'b11, 3'd0, DIR_IDLE, 3'd0, DIR_IDLE);
      set_hall(8'h14, 8'h00);
      exp_q.push_back({1'b0, 3'd2, 1'b1});
      expect_offer("rst first", 2);
      accept("rst first", 16'h0004);
      exp_q.push_back({1'b1, 3'd4, 1'b1});
      expect_offer("rst second", 2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst valid", 32'(asg_valid), 32'd0);
      check("rst mask",  32'(asg_mask),  32'd0);
      check("rst state", 32'(state),     32'(ST_IDLE));
      exp_q.push_back({1'b0, 3'd2, 1'b1});
      expect_offer("rst redispatch", 2);
      accept("rst redispatch", 16'h0004);

      // Both cars disabled
      do_reset();
      set_cars(2'b00, 3'd0, DIR_IDLE, 3'd0, DIR_IDLE);
      set_hall(8'h08, 8'h00);
      any_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (asg_valid) any_valid = 1'b1;
      end
      check("disabled no offer", 32'(any_valid), 32'd0);
      check("disabled state",    32'(state),     32'(ST_IDLE));
      car_en = 2'b10;
      exp_q.push_back({1'b1, 3'd3, 1'b1});
      expect_offer("enable car1", 2);
      accept("enable car1", 16'h0008);

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
